// File: rtl/pin_verify_ctrl.sv
// pin_verify_ctrl: scans a 4-digit stored PIN through the external 16:1 mux and compares it with the entered PIN,
// tracking consecutive failures per account and locking an account after MAX_TRIES of them.
module pin_verify_ctrl #(
   parameter int MAX_TRIES = 3
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [1:0]  Acct,
   input  logic [15:0] Entered,
   input  logic        Unlock,
   input  logic [1:0]  UnlockAcct,
   input  logic [3:0]  F,
   output logic        S3,
   output logic        S2,
   output logic        S1,
   output logic        S0,
   output logic        Busy,
   output logic        Done,
   output logic        Match,
   output logic        Locked,
   output logic [1:0]  FailCnt
);
   typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;
   localparam logic [1:0] MAX = 2'(MAX_TRIES);
   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic        busy_q, busy_d, done_q, done_d, match_q, match_d, locked_q, locked_d;
   logic [1:0]  fail_q, fail_d, acct_q, acct_d;
   logic [1:0]  cnt_q [4];
   logic [1:0]  cnt_d [4];
   logic [3:0]  lock_q, lock_d;
   logic [15:0] ent_q, ent_d;
   logic        mis_q, mis_d;
   logic        upd, res_mis, mis_now;
   logic [1:0]  ua, inc;
   logic [3:0]  digit;
   // the digit index is the low half of the registered select
   assign digit   = ent_q[{sel_q[1:0], 2'b00} +: 4];
   assign mis_now = mis_q | (F != digit);
   assign {S3, S2, S1, S0} = sel_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Match   = match_q;
   assign Locked  = locked_q;
   assign FailCnt = fail_q;
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      match_d  = match_q;
      locked_d = locked_q;
      fail_d   = fail_q;
      cnt_d    = cnt_q;
      lock_d   = lock_q;
      acct_d   = acct_q;
      ent_d    = ent_q;
      mis_d    = mis_q;
      upd      = 1'b0;
      ua       = acct_q;
      res_mis  = 1'b1;
      inc      = 2'd0;
      case (state_q)
         IDLE: if (Start) begin
            acct_d   = Acct;
            match_d  = 1'b0;
            locked_d = 1'b0;
            state_d  = lock_q[Acct] ? RESULT : SCAN;
            if (lock_q[Acct]) begin
               upd = 1'b1;
               ua  = Acct;
            end else begin
               ent_d  = Entered;
               mis_d  = 1'b0;
               sel_d  = {Acct, 2'b00};
               busy_d = 1'b1;
            end
         end
         SCAN: begin
            mis_d = mis_now;
            if (sel_q[1:0] == 2'd3) begin
               sel_d   = 4'd0;
               busy_d  = 1'b0;
               state_d = RESULT;
               upd     = 1'b1;
               res_mis = mis_now;
            end else sel_d = sel_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase
      if (Unlock) begin
         cnt_d[UnlockAcct]  = 2'd0;
         lock_d[UnlockAcct] = 1'b0;
      end
      // the result update is computed from pre-Unlock values so it wins on a same-account collision
      if (upd) begin
         inc        = (cnt_q[ua] == 2'd3) ? 2'd3 : cnt_q[ua] + 2'd1;
         cnt_d[ua]  = !res_mis ? 2'd0 : lock_q[ua] ? cnt_q[ua] : inc;
         lock_d[ua] = lock_q[ua] | (res_mis & (inc >= MAX));
         done_d     = 1'b1;
         match_d    = ~res_mis;
         locked_d   = lock_d[ua];
         fail_d     = cnt_d[ua];
      end
   end
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         sel_q    <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         match_q  <= 1'b0;
         locked_q <= 1'b0;
         fail_q   <= 2'd0;
         cnt_q    <= '{default: 2'd0};
         lock_q   <= 4'd0;
         acct_q   <= 2'd0;
         ent_q    <= 16'd0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         fail_q   <= fail_d;
         cnt_q    <= cnt_d;
         lock_q   <= lock_d;
         acct_q   <= acct_d;
         ent_q    <= ent_d;
         mis_q    <= mis_d;
      end
   end
endmodule

// File: tb/tb_pin_verify_ctrl.sv
// tb_pin_verify_ctrl: directed tests with a transaction-level model checked every cycle.
module tb_pin_verify_ctrl;
   localparam int MAX_TRIES = 3;
   logic        Clock, Reset, Start, Unlock;
   logic [1:0]  Acct, UnlockAcct, FailCnt;
   logic [15:0] Entered;
   logic [3:0]  F;
   logic        S3, S2, S1, S0, Busy, Done, Match, Locked;
   logic [3:0]  W [16];
   int n_cmp = 0, n_bad = 0;
   pin_verify_ctrl #(.MAX_TRIES(MAX_TRIES)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Acct(Acct), .Entered(Entered),
      .Unlock(Unlock), .UnlockAcct(UnlockAcct), .F(F), .S3(S3), .S2(S2), .S1(S1), .S0(S0),
      .Busy(Busy), .Done(Done), .Match(Match), .Locked(Locked), .FailCnt(FailCnt)
   );
   assign F = W[{S3, S2, S1, S0}];
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   function automatic void chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction
   int         ph = 0;
   logic [1:0] ma = 0, res_a = 0, oc = 0, nc = 0;
   logic [15:0] mpin = 0;
   logic [1:0] mcnt [4] = '{default: 2'd0};
   logic [3:0] mlock = 0;
   logic       was_done = 0, do_res = 0, res_mis = 0, ol = 0;
   logic [3:0] e_sel = 0;
   logic       e_busy = 0, e_done = 0, e_match = 0, e_locked = 0;
   logic [1:0] e_fail = 0;
   function automatic logic [15:0] stored(input logic [1:0] a);
      int b = int'(a) * 4;
      return {W[b+3], W[b+2], W[b+1], W[b]};
   endfunction
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ph = 0; e_sel = 0; e_busy = 0; e_done = 0; e_match = 0; e_locked = 0; e_fail = 0;
         mcnt = '{default: 2'd0}; mlock = 0; ma = 0; mpin = 0;
      end else begin
         was_done = e_done;
         e_done = 0;
         do_res = 0;
         if (ph == 4) begin
            do_res = 1; res_a = ma; res_mis = (mpin != stored(ma));
         end else if (ph > 0) begin
            e_sel = {ma, 2'(ph)};
            ph++;
         end else if (!was_done && Start) begin
            ma = Acct; e_match = 0; e_locked = 0;
            if (mlock[Acct]) begin
               do_res = 1; res_a = Acct; res_mis = 1;
            end else begin
               mpin = Entered; ph = 1; e_sel = {Acct, 2'b00}; e_busy = 1;
            end
         end
         oc = mcnt[res_a];
         ol = mlock[res_a];
         if (Unlock) begin
            mcnt[UnlockAcct] = 0;
            mlock[UnlockAcct] = 0;
         end
         if (do_res) begin
            nc = !res_mis ? 2'd0 : ol ? oc : (oc == 3 ? 2'd3 : oc + 2'd1);
            mcnt[res_a] = nc;
            mlock[res_a] = ol | (res_mis && int'(nc) >= MAX_TRIES);
            ph = 0; e_sel = 0; e_busy = 0; e_done = 1;
            e_match = !res_mis; e_locked = mlock[res_a]; e_fail = nc;
         end
      end
   end
   always @(posedge Clock) begin
      #1;
      chk("cycle", int'({S3, S2, S1, S0, Busy, Done, Match, Locked, FailCnt}),
          int'({e_sel, e_busy, e_done, e_match, e_locked, e_fail}));
   end
   task automatic verify(input logic [1:0] a, input logic [15:0] pin, input logic em, input logic el,
                         input logic [1:0] ef, input int elat, input logic [15:0] eseq);
      int lat;
      logic [15:0] seq;
      @(negedge Clock);
      Start = 1; Acct = a; Entered = pin;
      @(posedge Clock); #1;
      Start = 0;
      lat = 1;
      seq = {12'd0, S3, S2, S1, S0};
      while (!Done && lat < 10) begin
         @(posedge Clock); #1;
         lat++;
         if (lat <= 4) seq = {seq[11:0], S3, S2, S1, S0};
      end
      chk("latency", lat, elat);
      chk("select_seq", int'(seq), int'(eseq));
      chk("match", int'(Match), int'(em));
      chk("locked", int'(Locked), int'(el));
      chk("failcnt", int'(FailCnt), int'(ef));
      @(posedge Clock); #1;
      chk("done_pulse", int'(Done), 0);
   endtask
   initial begin
      int nd;
      logic m;
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
   initial begin
      int nd;
      logic m;
      Reset = 1; Start = 0; Unlock = 0; Acct = 0; UnlockAcct = 0; Entered = 0;
      W = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'h8, 4'h7, 4'h6, 4'h3, 4'h3, 4'h3, 4'h3};
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 0;
      chk("rst_sel", int'({S3, S2, S1, S0}), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_fail", int'(FailCnt), 0);
      verify(1, 16'h4321, 1, 0, 0, 5, 16'h4567);
      verify(1, 16'h5321, 0, 0, 1, 5, 16'h4567);
      verify(1, 16'h4320, 0, 0, 2, 5, 16'h4567);
      verify(1, 16'h4321, 1, 0, 0, 5, 16'h4567);
      verify(1, 16'h4331, 0, 0, 1, 5, 16'h4567);
      verify(2, 16'h0000, 0, 0, 1, 5, 16'h89AB);
      verify(2, 16'h6788, 0, 0, 2, 5, 16'h89AB);
      verify(2, 16'h1789, 0, 1, 3, 5, 16'h89AB);
      verify(2, 16'h6789, 0, 1, 3, 1, 16'h0000);
      @(negedge Clock);
      Unlock = 1; UnlockAcct = 2;
      @(negedge Clock);
      Unlock = 0;
      verify(2, 16'h6789, 1, 0, 0, 5, 16'h89AB);
      verify(3, 16'h3333, 1, 0, 0, 5, 16'hCDEF);
      @(negedge Clock);
      Start = 1; Acct = 1; Entered = 16'h4321;
      @(posedge Clock); #1;
      Start = 0;
      @(negedge Clock);
      Start = 1; Acct = 2; Entered = 16'h0000;
      @(posedge Clock); #1;
      Start = 0;
      nd = 0; m = 0;
      repeat (8) begin
         @(posedge Clock); #1;
         if (Done) begin nd++; m = Match; end
      end
      chk("busy_start_dones", nd, 1);
      chk("busy_start_match", int'(m), 1);
      verify(0, 16'h0000, 0, 0, 1, 5, 16'h0123);
      verify(0, 16'h0000, 0, 0, 2, 5, 16'h0123);
      verify(0, 16'h0000, 0, 1, 3, 5, 16'h0123);
      @(negedge Clock);
      Start = 1; Acct = 1; Entered = 16'h4321;
      @(posedge Clock); #1;
      Start = 0;
      @(posedge Clock); #2;
      Reset = 1;
      #1;
      chk("async_busy", int'(Busy), 0);
      chk("async_sel", int'({S3, S2, S1, S0}), 0);
      chk("async_fail", int'(FailCnt), 0);
      @(negedge Clock);
      Reset = 0;
      verify(0, 16'hFA50, 1, 0, 0, 5, 16'h0123);
      verify(1, 16'h4321, 1, 0, 0, 5, 16'h4567);
      repeat (2) @(posedge Clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
